// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder used as the serial adder's datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic Sum,
    output logic Carry
);

    assign Sum   = a ^ b ^ c;
    assign Carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit per clock, LSB first, result
// published WIDTH+1 edges after an accepted start.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic fa_sum;
    logic fa_carry;
    logic last_bit;

    full_adder u_full_adder (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .Sum   (fa_sum),
        .Carry (fa_carry)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Result fills from the MSB end so bit 0 lands last in place.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                if (last_bit) begin
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

    logic        clk;
    logic        rst;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;

    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    int n_checks;
    int n_err;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait for done; lat counts edges after the accept edge.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, output int lat);
        start8 = 1'b1; a8 = ta; b8 = tb_v; cin8 = tc;
        tick;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            tick;
            lat++;
        end
        $display("txn w8  a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h lat=%0d", ta, tb_v, tc, cout8, sum8, lat);
    endtask

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, output int lat);
        start16 = 1'b1; a16 = ta; b16 = tb_v; cin16 = tc;
        tick;
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 60) begin
            tick;
            lat++;
        end
        $display("txn w16 a=%04h b=%04h cin=%0d -> cout=%0d sum=%04h lat=%0d", ta, tb_v, tc, cout16, sum16, lat);
    endtask

    initial begin
        int lat;
        int cnt;
        int first_edge;
        int pulses;
        int hold_bad;
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;
        logic        rc;
        logic [8:0]  exp9;
        logic [16:0] exp17;

        n_checks = 0;
        n_err    = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        tick;
        tick;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        rst = 1'b0;
        tick;

        // Zero operands: busy exactly 8 cycles, then a single done cycle.
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        tick;
        start8 = 1'b0;
        cnt = 0; lat = 0;
        while (!done8 && lat < 40) begin
            if (busy8) cnt++;
            tick;
            lat++;
        end
        $display("txn w8  a=00 b=00 cin=0 -> cout=%0d sum=%02h busy_cycles=%0d", cout8, sum8, cnt);
        check("zero_busy_cycles", 32'(cnt), 32'd8);
        check("zero_lat", 32'(lat), 32'd8);
        check("zero_sum", 32'(sum8), 32'h00);
        check("zero_cout", 32'(cout8), 32'd0);
        tick;
        check("done_one_cycle", 32'(done8), 32'd0);

        op8(8'hFF, 8'h01, 1'b0, lat);
        check("ff01_sum", 32'(sum8), 32'h00);
        check("ff01_cout", 32'(cout8), 32'd1);
        check("ff01_lat", 32'(lat), 32'd8);
        op8(8'hA5, 8'h5A, 1'b1, lat);
        check("a55a_sum", 32'(sum8), 32'h00);
        check("a55a_cout", 32'(cout8), 32'd1);
        tick;

        // Start pulsed mid-RUN with different operands must be ignored.
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0;
        tick;
        start8 = 1'b0;
        tick; tick; tick;
        start8 = 1'b1; a8 = 8'hFF;
        tick;
        start8 = 1'b0; a8 = 8'h00;
        pulses = 0; first_edge = 0;
        for (int i = 5; i <= 24; i++) begin
            tick;
            if (done8) begin
                pulses++;
                if (first_edge == 0) first_edge = i;
            end
        end
        $display("txn w8  a=3C b=0F cin=0 (+ignored start) -> cout=%0d sum=%02h pulses=%0d", cout8, sum8, pulses);
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_edge", 32'(first_edge), 32'd8);
        check("ign_sum", 32'(sum8), 32'h4B);
        check("ign_cout", 32'(cout8), 32'd0);

        // Reset at edge k+4 aborts the addition and clears the published result.
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        tick;
        start8 = 1'b0;
        tick; tick; tick;
        check("abort_busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'h00);
        check("abort_cout", 32'(cout8), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done8) pulses++;
        end
        $display("txn w8  a=80 b=80 cin=0 aborted -> cout=%0d sum=%02h", cout8, sum8);
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_sum_after", 32'(sum8), 32'h00);

        // Back-to-back: start held in DONE, previous sum held through the RUN.
        op8(8'h10, 8'h20, 1'b0, lat);
        check("b2b_first_sum", 32'(sum8), 32'h30);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        tick;
        start8 = 1'b0;
        cnt = 1; hold_bad = 0;
        while (!done8 && cnt < 40) begin
            if (sum8 !== 8'h30) hold_bad++;
            tick;
            cnt++;
        end
        $display("txn w8  a=01 b=02 cin=0 back-to-back -> cout=%0d sum=%02h gap=%0d", cout8, sum8, cnt);
        check("b2b_hold", 32'(hold_bad), 32'd0);
        check("b2b_gap", 32'(cnt), 32'd9);
        check("b2b_sum", 32'(sum8), 32'h03);
        check("b2b_cout", 32'(cout8), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom);
            exp9 = {1'b0, ra8} + {1'b0, rb8} + {8'd0, rc};
            op8(ra8, rb8, rc, lat);
            check("rnd8_result", 32'({cout8, sum8}), 32'(exp9));
            check("rnd8_lat", 32'(lat), 32'd8);
        end

        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom); rb16 = 16'($urandom); rc = 1'($urandom);
            exp17 = {1'b0, ra16} + {1'b0, rb16} + {16'd0, rc};
            op16(ra16, rb16, rc, lat);
            check("rnd16_result", 32'({cout16, sum16}), 32'(exp17));
            check("rnd16_lat", 32'(lat), 32'd16);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range is WIDTH >= 2.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an addition, sampled on clk rising edge.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 The block SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy  output  1  high while bits are being processed.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when a result is published.
REQ-010 The block SHALL have port sum  output  WIDTH  registered result of the last completed addition.
REQ-011 The block SHALL have port cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE with start=1 at edge k, the block SHALL capture a, b and cin, clear the bit counter, and enter RUN.
REQ-014 In RUN, each edge SHALL add the LSBs of the operand shift registers and the carry flop through one full adder, shift the sum bit into the result shift register from the MSB end, right-shift both operands, and store the carry.
REQ-015 RUN SHALL last exactly WIDTH edges (k+1..k+WIDTH); the counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap before leaving RUN.
REQ-016 On edge k+WIDTH the block SHALL copy the result register to sum, copy the final carry to cout, and enter DONE, so done is high for the cycle after edge k+WIDTH (latency WIDTH+1 edges from start).
REQ-017 DONE SHALL return to IDLE on the next edge unless start=1, in which case REQ-013 applies (back-to-back operation, no bubble).
REQ-018 busy SHALL equal (state == RUN); done SHALL equal (state == DONE).
REQ-019 start asserted in RUN SHALL be ignored and SHALL NOT disturb the operation in flight.
REQ-020 sum and cout SHALL hold the previous result throughout RUN and SHALL change only on the REQ-016 edge.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH, with overflow reported only through cout; {cout,sum} SHALL equal a+b+cin.

Reset
REQ-022 With rst=1 at an edge, the block SHALL enter IDLE and SHALL clear sum, cout, the carry flop, the counter and the shift registers, with busy=0 and done=0 after that edge.
REQ-023 rst SHALL take priority over start and over any in-flight operation; an aborted addition SHALL produce no done pulse and SHALL leave sum=0 and cout=0.

Structure
REQ-024 Package serial_adder_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-025 The per-bit addition SHALL be one instance of the team's existing combinational full_adder sub-module, with ports (a, b, c, Sum, Carry); there SHALL be no other sub-modules.
REQ-026 All state SHALL be held in flops clocked by clk only, with no latches and no combinational path from start to done.

Verification (WIDTH=8)
REQ-027 Stimulus a=0x00, b=0x00, cin=0, start for one cycle -> busy for 8 cycles, then done for one cycle with sum=0x00 and cout=0.
REQ-028 Stimulus a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; additionally a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-029 Stimulus a=0x3C, b=0x0F, cin=0, then start with a=0xFF pulsed mid-RUN -> a single done pulse with sum=0x4B and cout=0; the second start is ignored.
REQ-030 Stimulus: start a=0x80, b=0x80, then rst=1 at edge k+4 -> busy=0, done is never pulsed, and sum=0x00, cout=0.
REQ-031 Stimulus: start held during DONE with a=0x01, b=0x02 -> next done exactly 9 edges later with sum=0x03; sum keeps the first result during the second RUN.
REQ-032 Randomised check of 1000 operand triples at WIDTH=8 and WIDTH=16 -> {cout,sum} equals a+b+cin, and every done pulse falls exactly WIDTH+1 edges after the accepted start.
